// File: rtl/resp_mem_dados.sv
// Data-memory responder: one load/store at a time, programmable wait, RV32I sizing in the memory.
// Define MEM_DADOS_ERR_EN to enable fault checks (misaligned, out-of-window, unsupported funct3).
module resp_mem_dados #(
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iReq,
    input  logic        iWrite,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWData,
    output logic        oReady,
    output logic        oValid,
    output logic [31:0] oRData,
    output logic        oErr
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic           regWrite;
    logic [2:0]     regFunct3;
    logic [31:0]    regAddr;
    logic [31:0]    regWData;

    logic [31:0]    mem [2**ADDR_BITS];

    logic           curWrite;
    logic [2:0]     curFunct3;
    logic [31:0]    curAddr;
    logic [31:0]    curWData;
    logic [31:0]    offset;
    logic [ADDR_BITS-1:0] wordIdx;
    logic [1:0]     lane;
    logic           isByte;
    logic           isHalf;
    logic           fault;
    logic           enterResp;
    logic           commit;
    logic [3:0]     byteEn;
    logic [31:0]    wdLanes;
    logic [31:0]    ramWord;
    logic [7:0]     byteSel;
    logic [15:0]    halfSel;
    logic [31:0]    rdFmt;

    // With WAIT_CYCLES=0 the accept edge is also the response edge, so decode straight from the inputs.
    assign curWrite  = (state == IDLE) ? iWrite  : regWrite;
    assign curFunct3 = (state == IDLE) ? iFunct3 : regFunct3;
    assign curAddr   = (state == IDLE) ? iAddr   : regAddr;
    assign curWData  = (state == IDLE) ? iWData  : regWData;

    assign offset  = curAddr - BASE_ADDR;
    assign wordIdx = ADDR_BITS'(offset >> 2);
    assign lane    = curAddr[1:0];
    assign isByte  = (curFunct3[1:0] == 2'b00);
    assign isHalf  = (curFunct3[1:0] == 2'b01);

`ifdef MEM_DADOS_ERR_EN
    logic unsupported;
    logic misaligned;
    logic outWin;
    logic errFlag;

    assign unsupported = (curFunct3 == 3'b011) || (curFunct3[2:1] == 2'b11);
    assign misaligned  = (isHalf && lane[0]) || (!isByte && !isHalf && (lane != 2'b00));
    assign outWin      = |(offset >> (ADDR_BITS + 2));
    assign fault       = unsupported || misaligned || outWin;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)
            errFlag <= 1'b0;
        else if (enterResp)
            errFlag <= fault;
    end
    assign oErr = errFlag;
`else
    assign fault = 1'b0;
    assign oErr  = 1'b0;
`endif

    assign enterResp = ((state == IDLE) && iReq && (WAIT_CYCLES == 0)) ||
                       ((state == WAIT) && (cnt == 4'(WAIT_CYCLES)));
    assign commit    = enterResp && curWrite && !fault && !iRST;

    always_comb begin
        byteEn  = 4'b1111;
        wdLanes = curWData;
        if (isByte) begin
            byteEn  = 4'b0001 << lane;
            wdLanes = {4{curWData[7:0]}};
        end else if (isHalf) begin
            byteEn  = lane[1] ? 4'b1100 : 4'b0011;
            wdLanes = {2{curWData[15:0]}};
        end
    end

    assign ramWord = mem[wordIdx];
    assign byteSel = ramWord[{lane, 3'b000} +: 8];
    assign halfSel = lane[1] ? ramWord[31:16] : ramWord[15:0];

    always_comb begin
        rdFmt = ramWord;
        if (isByte)
            rdFmt = {{24{~curFunct3[2] & byteSel[7]}}, byteSel};
        else if (isHalf)
            rdFmt = {{16{~curFunct3[2] & halfSel[15]}}, halfSel};
    end

    always_ff @(posedge iCLK) begin
        if (commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byteEn[i])
                    mem[wordIdx][8*i +: 8] <= wdLanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state     <= IDLE;
            cnt       <= '0;
            oReady    <= 1'b1;
            oValid    <= 1'b0;
            oRData    <= '0;
            regWrite  <= 1'b0;
            regFunct3 <= '0;
            regAddr   <= '0;
            regWData  <= '0;
        end else begin
            oValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (iReq) begin
                        regWrite  <= iWrite;
                        regFunct3 <= iFunct3;
                        regAddr   <= iAddr;
                        regWData  <= iWData;
                        oReady    <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'd1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'(WAIT_CYCLES))
                        state <= RESP;
                    else
                        cnt <= cnt + 4'd1;
                end
                RESP: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    oReady <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (enterResp) begin
                oValid <= 1'b1;
                oRData <= (curWrite || fault) ? '0 : rdFmt;
            end
        end
    end

endmodule

// File: tb/tb_resp_mem_dados.sv
// Directed bench for resp_mem_dados: one WAIT_CYCLES=1 instance and one WAIT_CYCLES=0 instance.
module tb_resp_mem_dados;

    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iReq = 1'b0, iWrite = 1'b0;
    logic [2:0]  iFunct3 = '0;
    logic [31:0] iAddr = '0, iWData = '0;
    logic        oReady, oValid, oErr;
    logic [31:0] oRData;

    logic        iReq0 = 1'b0, iWrite0 = 1'b0;
    logic [2:0]  iFunct30 = '0;
    logic [31:0] iAddr0 = '0, iWData0 = '0;
    logic        oReady0, oValid0, oErr0;
    logic [31:0] oRData0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    resp_mem_dados #(.ADDR_BITS(10), .WAIT_CYCLES(1), .BASE_ADDR(BASE)) dut (
        .iCLK(clk), .iRST(rst), .iReq(iReq), .iWrite(iWrite), .iFunct3(iFunct3),
        .iAddr(iAddr), .iWData(iWData), .oReady(oReady), .oValid(oValid),
        .oRData(oRData), .oErr(oErr));

    resp_mem_dados #(.ADDR_BITS(10), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) dut0 (
        .iCLK(clk), .iRST(rst), .iReq(iReq0), .iWrite(iWrite0), .iFunct3(iFunct30),
        .iAddr(iAddr0), .iWData(iWData0), .oReady(oReady0), .oValid(oValid0),
        .oRData(oRData0), .oErr(oErr0));

    // Drives one request on the WAIT_CYCLES=1 instance; lat counts cycles from the request cycle to oValid.
    task automatic do_op(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat, output logic after);
        int n = 0;
        @(negedge clk);
        while (!oReady && n < 20) begin @(negedge clk); n++; end
        iReq = 1'b1; iWrite = w; iFunct3 = f3; iAddr = a; iWData = wd;
        @(posedge clk); #1;
        iReq = 1'b0; iFunct3 = 3'b111; iAddr = 32'hFFFF_FFFF; iWData = $urandom;
        lat = 1;
        while (!oValid && lat < 20) begin @(posedge clk); #1; lat++; end
        rd = oRData; er = oErr;
        @(posedge clk); #1;
        after = oValid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", oReady); end
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", oValid); end
        checks++; if (oRData !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", oRData); end
        checks++; if (oErr !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", oErr); end
        checks++; if (oReady0 !== 1'b1 || oValid0 !== 1'b0) begin errors++; $display("FAIL rst0_hs got %b%b exp 10", oReady0, oValid0); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er, af; int lat;
        do_op(1'b1, F_W, BASE, 32'hDEADBEEF, rd, er, lat, af);
        checks++; if (lat != 2) begin errors++; $display("FAIL sw_latency got %0d exp 2", lat); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sw_rdata got %h exp 0", rd); end
        checks++; if (af !== 1'b0) begin errors++; $display("FAIL sw_valid_width got %b exp 0", af); end
        do_op(1'b0, F_W, BASE, 32'h0, rd, er, lat, af);
        checks++; if (lat != 2) begin errors++; $display("FAIL lw_latency got %0d exp 2", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err got %b exp 0", er); end
        checks++; if (af !== 1'b0 || oReady !== 1'b1) begin errors++; $display("FAIL lw_after got v%b r%b exp v0 r1", af, oReady); end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic er, af; int lat;
        do_op(1'b1, F_W, BASE + 4, 32'h11223344, rd, er, lat, af);
        do_op(1'b1, F_B, BASE + 5, 32'h12345680, rd, er, lat, af);
        do_op(1'b0, F_B, BASE + 5, 32'h0, rd, er, lat, af);
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext got %h exp ffffff80", rd); end
        do_op(1'b0, F_BU, BASE + 5, 32'h0, rd, er, lat, af);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_zext got %h exp 00000080", rd); end
        do_op(1'b0, F_W, BASE + 4, 32'h0, rd, er, lat, af);
        checks++; if (rd !== 32'h11228044) begin errors++; $display("FAIL sb_merge got %h exp 11228044", rd); end
        do_op(1'b0, F_B, BASE + 7, 32'h0, rd, er, lat, af);
        checks++; if (rd !== 32'h00000011) begin errors++; $display("FAIL lb_lane3 got %h exp 00000011", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic er, af; int lat;
        do_op(1'b1, F_H, BASE + 2, 32'hFFFF1234, rd, er, lat, af);
        do_op(1'b0, F_W, BASE, 32'h0, rd, er, lat, af);
        checks++; if (rd !== 32'h1234BEEF) begin errors++; $display("FAIL sh_merge got %h exp 1234beef", rd); end
        do_op(1'b0, F_H, BASE + 2, 32'h0, rd, er, lat, af);
        checks++; if (rd !== 32'h00001234) begin errors++; $display("FAIL lh_hi got %h exp 00001234", rd); end
        do_op(1'b0, F_H, BASE, 32'h0, rd, er, lat, af);
        checks++; if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_sext got %h exp ffffbeef", rd); end
        do_op(1'b0, F_HU, BASE, 32'h0, rd, er, lat, af);
        checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_zext got %h exp 0000beef", rd); end
    endtask

`ifdef MEM_DADOS_ERR_EN
    task automatic test_faults();
        logic [31:0] rd, v0; logic er, af; int lat;
        do_op(1'b0, F_W, BASE + 2, 32'h0, rd, er, lat, af);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_misal got e%b %h exp e1 0", er, rd); end
        checks++; if (lat != 2) begin errors++; $display("FAIL fault_latency got %0d exp 2", lat); end
        do_op(1'b0, F_W, BASE + 32'hFFC, 32'h0, v0, er, lat, af);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_last_err got %b exp 0", er); end
        do_op(1'b1, F_W, BASE - 4, 32'hCAFEF00D, rd, er, lat, af);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL sw_below got e%b %h exp e1 0", er, rd); end
        do_op(1'b0, F_W, BASE + 32'hFFC, 32'h0, rd, er, lat, af);
        checks++; if (rd !== v0) begin errors++; $display("FAIL sw_below_nowrite got %h exp %h", rd, v0); end
        do_op(1'b0, F_W, BASE + 32'h1000, 32'h0, rd, er, lat, af);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL lw_above got %b exp 1", er); end
        do_op(1'b0, 3'b011, BASE, 32'h0, rd, er, lat, af);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL f3_unsup got %b exp 1", er); end
        do_op(1'b1, F_H, BASE + 1, 32'h00005678, rd, er, lat, af);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL sh_misal got %b exp 1", er); end
        do_op(1'b0, F_W, BASE, 32'h0, rd, er, lat, af);
        checks++; if (rd !== 32'h1234BEEF || er !== 1'b0) begin errors++; $display("FAIL sh_misal_nowrite got e%b %h exp e0 1234beef", er, rd); end
    endtask
`else
    task automatic test_faults();
        logic [31:0] rd; logic er, af; int lat;
        do_op(1'b0, F_W, BASE + 2, 32'h0, rd, er, lat, af);
        checks++; if (er !== 1'b0 || rd !== 32'h1234BEEF) begin errors++; $display("FAIL lw_aligndown got e%b %h exp e0 1234beef", er, rd); end
        do_op(1'b0, F_H, BASE + 3, 32'h0, rd, er, lat, af);
        checks++; if (rd !== 32'h00001234) begin errors++; $display("FAIL lh_aligndown got %h exp 00001234", rd); end
        do_op(1'b1, F_W, BASE - 4, 32'hCAFEF00D, rd, er, lat, af);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw_wrap_err got %b exp 0", er); end
        do_op(1'b0, F_W, BASE + 32'hFFC, 32'h0, rd, er, lat, af);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL sw_wrap got %h exp cafef00d", rd); end
        do_op(1'b0, 3'b011, BASE, 32'h0, rd, er, lat, af);
        checks++; if (rd !== 32'h1234BEEF) begin errors++; $display("FAIL f3_as_word got %h exp 1234beef", rd); end
        do_op(1'b1, F_H, BASE + 1, 32'h00005678, rd, er, lat, af);
        do_op(1'b0, F_W, BASE, 32'h0, rd, er, lat, af);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL sh_aligndown got %h exp 12345678", rd); end
    endtask
`endif

    task automatic test_back_to_back();
        @(negedge clk);
        iReq0 = 1'b1; iWrite0 = 1'b1; iFunct30 = F_W; iAddr0 = BASE; iWData0 = 32'hA5A50F0F;
        @(posedge clk); #1;
        checks++; if (oValid0 !== 1'b1 || oReady0 !== 1'b0) begin errors++; $display("FAIL w0_sw_resp got v%b r%b exp v1 r0", oValid0, oReady0); end
        @(negedge clk); iReq0 = 1'b0;
        @(posedge clk); #1;
        checks++; if (oValid0 !== 1'b0 || oReady0 !== 1'b1) begin errors++; $display("FAIL w0_idle got v%b r%b exp v0 r1", oValid0, oReady0); end
        @(negedge clk);
        iReq0 = 1'b1; iWrite0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (oValid0 !== (i % 2 == 0) || oReady0 !== (i % 2 == 1)) begin
                errors++; $display("FAIL hold_req_c%0d got v%b r%b exp v%b r%b", i, oValid0, oReady0, i % 2 == 0, i % 2 == 1);
            end
            if (i % 2 == 0) begin
                checks++; if (oRData0 !== 32'hA5A50F0F) begin errors++; $display("FAIL hold_req_data%0d got %h exp a5a50f0f", i, oRData0); end
            end
        end
        @(negedge clk); iReq0 = 1'b0;
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd; logic er, af; int lat;
        logic seen = 1'b0;
        do_op(1'b1, F_W, BASE + 8, 32'h01020304, rd, er, lat, af);
        @(negedge clk);
        iReq = 1'b1; iWrite = 1'b1; iFunct3 = F_W; iAddr = BASE + 8; iWData = 32'h5555AAAA;
        @(posedge clk); #1;
        iReq = 1'b0;
        checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL wait_ready got %b exp 0", oReady); end
        #2 rst = 1'b1;
        #1;
        checks++; if (oReady !== 1'b1 || oValid !== 1'b0) begin errors++; $display("FAIL async_rst got r%b v%b exp r1 v0", oReady, oValid); end
        @(posedge clk); #3 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (oValid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_abandon got valid %b exp 0", seen); end
        checks++; if (oReady !== 1'b1 || oRData !== 32'h0) begin errors++; $display("FAIL rst_after got r%b %h exp r1 0", oReady, oRData); end
        do_op(1'b0, F_W, BASE + 8, 32'h0, rd, er, lat, af);
        checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL rst_discard got %h exp 01020304", rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_faults();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
